// File: rtl/uart_pkg.sv
// Shared state encoding and default parameters for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitAcc  = 2'd1,
    StWaitDone = 2'd2
  } arb_state_e;

  localparam int unsigned DefNReq    = 4;
  localparam int unsigned DefWidth   = 8;
  localparam int unsigned DefTimeout = 15;
  localparam int unsigned FrameCntW  = 16;

endpackage

// File: rtl/rr_picker.sv
// Round-robin requester selection: rotate so ptr sits at bit 0, take the lowest
// set bit, then rotate the index back.
module rr_picker
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ = DefNReq
) (
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     any,
  output logic [$clog2(N_REQ)-1:0] winner
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [IdxW-1:0]    offset;
  logic [IdxW:0]      sum;

  assign doubled = {req_valid, req_valid};
  assign rotated = N_REQ'(doubled >> ptr);
  assign any     = |req_valid;

  always_comb begin
    offset = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IdxW'(i);
    end
  end

  // Explicit modulo so non-power-of-two requester counts wrap correctly.
  assign sum    = {1'b0, offset} + {1'b0, ptr};
  assign winner = (sum >= (IdxW + 1)'(N_REQ)) ? IdxW'(sum - (IdxW + 1)'(N_REQ))
                                              : sum[IdxW-1:0];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between several byte producers,
// with start-acknowledge timeout and a completed-frame counter.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ   = DefNReq,
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic                     clk_baud,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_start,
  output logic [WIDTH-1:0]         tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     arb_busy,
  output logic                     timeout_err,
  output logic [FrameCntW-1:0]     frame_cnt
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  arb_state_e           state_q, state_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0]     ready_q, ready_d;
  logic                 start_q, start_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [IdxW-1:0]      gid_q, gid_d;
  logic                 tout_q, tout_d;
  logic [FrameCntW-1:0] frames_q, frames_d;

  logic                 pick_any;
  logic [IdxW-1:0]      pick_idx;
  logic [WIDTH-1:0]     pick_data;
  logic [IdxW-1:0]      next_ptr;

  rr_picker #(
    .N_REQ(N_REQ)
  ) u_picker (
    .req_valid(req_valid),
    .ptr      (ptr_q),
    .any      (pick_any),
    .winner   (pick_idx)
  );

  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_idx == IdxW'(i)) pick_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // The pointer always moves one past the last granted requester, served or not.
  assign next_ptr = (gid_q == IdxW'(N_REQ - 1)) ? '0 : gid_q + IdxW'(1);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ready_d  = '0;
    start_d  = 1'b0;
    data_d   = data_q;
    gid_d    = gid_q;
    tout_d   = 1'b0;
    frames_d = frames_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          gid_d   = pick_idx;
          data_d  = pick_data;
          ready_d = N_REQ'(1) << pick_idx;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = StWaitAcc;
        end
      end
      StWaitAcc: begin
        // A busy rise on the expiry cycle still counts as accepted.
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntLast) begin
          tout_d  = 1'b1;
          ptr_d   = next_ptr;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          frames_d = frames_q + FrameCntW'(1);
          ptr_d    = next_ptr;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_baud or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      cnt_q    <= '0;
      ready_q  <= '0;
      start_q  <= 1'b0;
      data_q   <= '0;
      gid_q    <= '0;
      tout_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      start_q  <= start_d;
      data_q   <= data_d;
      gid_q    <= gid_d;
      tout_q   <= tout_d;
      frames_q <= frames_d;
    end
  end

  assign req_ready   = ready_q;
  assign tx_start    = start_q;
  assign tx_data     = data_q;
  assign grant_id    = gid_q;
  assign arb_busy    = (state_q != StIdle);
  assign timeout_err = tout_q;
  assign frame_cnt   = frames_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter against a transaction-level
// round-robin model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 15;

  logic           clk_baud = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [W-1:0]   tx_data;
  logic           tx_busy = 1'b0;
  logic [1:0]     grant_id;
  logic           arb_busy;
  logic           timeout_err;
  logic [15:0]    frame_cnt;

  uart_tx_arbiter #(
    .N_REQ  (N),
    .WIDTH  (W),
    .TIMEOUT(TO)
  ) dut (
    .clk_baud   (clk_baud),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .arb_busy   (arb_busy),
    .timeout_err(timeout_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk_baud = ~clk_baud;

  int          checks = 0;
  int          errors = 0;
  int          m_ptr = 0;
  int unsigned m_frames = 0;
  logic [W-1:0] m_byte = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_baud);
    #1;
  endtask

  // First valid requester at or after the pointer, wrapping around.
  function automatic int model_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic grant(input logic [N-1:0] v, input logic [N*W-1:0] d, output int w);
    req_valid = v;
    req_data  = d;
    w = model_pick(v, m_ptr);
    m_byte = d[w*W +: W];
    tick();
    check("tx_start", tx_start, 1);
    check("req_ready", req_ready, 32'(1) << w);
    check("grant_id", grant_id, w);
    check("tx_data", tx_data, m_byte);
    check("arb_busy_grant", arb_busy, 1);
  endtask

  // tx_busy rises d cycles after tx_start and stays high for len cycles.
  task automatic finish_frame(input int w, input int d, input int len);
    tx_busy = 1'b0;
    for (int i = 1; i <= d; i++) begin
      tick();
      if (i == 1) begin
        check("start_drop", tx_start, 0);
        check("ready_drop", req_ready, 0);
      end
    end
    tx_busy = 1'b1;
    for (int i = 0; i < len; i++) tick();
    check("busy_hold", arb_busy, 1);
    check("no_timeout", timeout_err, 0);
    tx_busy = 1'b0;
    tick();
    m_frames = (m_frames + 1) & 32'hFFFF;
    m_ptr = (w + 1) % N;
    check("frame_cnt", frame_cnt, m_frames);
    check("idle_after", arb_busy, 0);
    check("data_held", tx_data, m_byte);
    req_valid = '0;
  endtask

  task automatic timeout_frame(input int w);
    tx_busy = 1'b0;
    for (int i = 1; i < TO; i++) begin
      tick();
      check("no_early_timeout", timeout_err, 0);
    end
    tick();
    check("timeout_err", timeout_err, 1);
    check("timeout_idle", arb_busy, 0);
    check("timeout_frames", frame_cnt, m_frames);
    req_valid = '0;
    m_ptr = (w + 1) % N;
    tick();
    check("timeout_pulse_end", timeout_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    logic [31:0] rd;
    logic [N-1:0] rv;

    #2 rst = 1'b0;
    tick();
    tick();
    check("rst_ready", req_ready, 0);
    check("rst_start", tx_start, 0);
    check("rst_data", tx_data, 0);
    check("rst_gid", grant_id, 0);
    check("rst_busy", arb_busy, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_frames", frame_cnt, 0);
    rst = 1'b1;
    tick();
    tick();
    check("idle_no_start", tx_start, 0);

    // Fairness with all requesters valid.
    for (int i = 0; i < 5; i++) begin
      grant(4'b1111, 32'h1312_1110, w);
      check("fair_seq", w, i % 4);
      finish_frame(w, 1 + (i % 3), 2);
    end

    // Single request, busy 2 cycles after start for 10 cycles.
    grant(4'b0100, 32'h00A5_0000, w);
    check("single_gid", grant_id, 2);
    finish_frame(w, 2, 10);

    // Pointer skip.
    grant(4'b0010, 32'h0000_3C00, w);
    finish_frame(w, 1, 1);
    grant(4'b1010, 32'h7700_6600, w);
    check("skip_first", grant_id, 3);
    finish_frame(w, 3, 4);
    grant(4'b1010, 32'h7700_6600, w);
    check("skip_second", grant_id, 1);
    finish_frame(w, 1, 2);

    // Timeout, then the following grant moves one past it.
    grant(4'b1111, 32'hDDCC_BBAA, w);
    timeout_frame(w);
    grant(4'b1111, 32'hDDCC_BBAA, w);
    finish_frame(w, 2, 3);

    // Busy rises exactly on the expiry cycle: accepted, no timeout.
    grant(4'b0001, 32'h0000_0042, w);
    finish_frame(w, TO - 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      rv = N'($urandom_range(1, 15));
      rd = $urandom;
      grant(rv, rd, w);
      if ($urandom_range(0, 7) == 0) timeout_frame(w);
      else finish_frame(w, int'($urandom_range(1, TO - 1)), int'($urandom_range(1, 6)));
    end

    // Frame counter wrap from a preloaded value.
    force dut.frames_q = 16'hFFFE;
    tick();
    tick();
    release dut.frames_q;
    m_frames = 32'hFFFE;
    tick();
    check("preload", frame_cnt, 16'hFFFE);
    grant(4'b0110, 32'h0012_3400, w);
    finish_frame(w, 1, 1);
    check("cnt_ffff", frame_cnt, 16'hFFFF);
    grant(4'b1001, 32'h5600_0078, w);
    finish_frame(w, 2, 2);
    check("cnt_wrap", frame_cnt, 0);
    check("wrap_no_timeout", timeout_err, 0);

    // Asynchronous reset in the middle of a frame.
    grant(4'b0100, 32'h00A5_0000, w);
    tx_busy = 1'b0;
    tick();
    tx_busy = 1'b1;
    tick();
    tick();
    check("mid_frame_busy", arb_busy, 1);
    #3 rst = 1'b0;
    #1;
    check("arst_ready", req_ready, 0);
    check("arst_start", tx_start, 0);
    check("arst_data", tx_data, 0);
    check("arst_gid", grant_id, 0);
    check("arst_busy", arb_busy, 0);
    check("arst_timeout", timeout_err, 0);
    check("arst_frames", frame_cnt, 0);
    tx_busy   = 1'b0;
    req_valid = '0;
    tick();
    rst = 1'b1;
    m_ptr = 0;
    m_frames = 0;
    tick();
    grant(4'b0001, 32'h0000_0081, w);
    check("post_rst_gid", grant_id, 0);
    finish_frame(w, 1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between N_REQ requesters, each presenting one WIDTH-bit byte at a time.
- Grants requesters in round-robin order, latches the winning byte, and pulses tx_start to the transmitter.
- Tracks the transmitter's tx_busy to detect frame completion, flags a timeout if tx_busy never rises, and counts completed frames.
- Sits between the application-side producers and the UART TX framing block, in the clk_baud domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, data bits per frame.
- TIMEOUT, 15, cycles allowed after tx_start for tx_busy to rise (1..255).

Ports:
- clk_baud  in  1  baud clock; single clock of the block
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester byte valid
- req_data  in  N_REQ*WIDTH  packed bytes; requester i occupies [i*WIDTH +: WIDTH]
- req_ready  out  N_REQ  one-cycle accept pulse, at most one bit high
- tx_start  out  1  one-cycle start pulse to the transmitter
- tx_data  out  WIDTH  byte to transmit; held until the next grant
- tx_busy  in  1  transmitter is sending a frame
- grant_id  out  $clog2(N_REQ)  index of the current or last granted requester
- arb_busy  out  1  high whenever state != IDLE
- timeout_err  out  1  one-cycle pulse on timeout
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset: asynchronous on rst low. State=IDLE; rr pointer=0. All outputs 0: req_ready, tx_start, tx_data, grant_id, arb_busy, timeout_err, frame_cnt. An in-flight frame is abandoned without a completion count.

FSM states:
- IDLE:
  - If any req_valid is high at an edge: winner = first set bit searching from ptr upward, wrapping at N_REQ.
  - In the cycle after that edge: grant_id=winner, tx_data=req_data[winner], req_ready[winner]=1, tx_start=1.
  - Next state WAIT_ACC; timeout counter cleared.
  - Request-to-start latency is one edge.
- WAIT_ACC:
  - tx_start and req_ready return to 0.
  - If tx_busy=1: go to WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with tx_busy still 0:
    - timeout_err pulses for one cycle.
    - ptr=grant_id+1 mod N_REQ.
    - Next state IDLE. The byte is dropped and frame_cnt is unchanged.
- WAIT_DONE:
  - When tx_busy=0: frame_cnt+1, ptr=grant_id+1 mod N_REQ, next state IDLE.
  - No timeout is applied in this state.

Handshake rules:
- A requester holds req_valid high with req_data stable until it samples req_ready=1.
- It may reassert valid with a new byte in the cycle after req_ready.
- req_valid changes while the FSM is not in IDLE are ignored; no grant is issued outside IDLE.
- Minimum grant spacing is 3 cycles: IDLE, WAIT_ACC, WAIT_DONE.

Other rules:
- Simultaneous tx_busy rise and timeout expiry: tx_busy wins, go to WAIT_DONE.
- Pointer arithmetic wraps modulo N_REQ. This must hold for non-power-of-2 N_REQ: with N_REQ=3, ptr goes 2->0.
- tx_data is not cleared after the frame; it changes only on the next grant.

Decomposition:
- Shared package uart_pkg:
  - FSM state encodings IDLE/WAIT_ACC/WAIT_DONE.
  - Default N_REQ, WIDTH, TIMEOUT constants.
- Sub-module rr_picker: combinational.
  - Inputs: req_valid, ptr.
  - Outputs: any, winner index.
  - Rotate, priority-encode, rotate back.
- The FSM, counters and output registers live in uart_tx_arbiter.

Test Plan:
1. Single request: req_valid=4'b0100, req_data[2]=0xA5, tx_busy rises 2 cycles after tx_start and falls 10 cycles later -> one cycle after the edge: tx_start=1, tx_data=0xA5, req_ready=4'b0100, grant_id=2. frame_cnt=1 after tx_busy falls; state returns to IDLE.
2. Fairness: all four requesters continuously valid with data 0x10/0x11/0x12/0x13, and a transmitter model that completes every frame -> grant_id sequence 0,1,2,3,0 and tx_data sequence 0x10,0x11,0x12,0x13,0x10.
3. Pointer skip: ptr=2 (after a grant to 1), req_valid=4'b1010 -> grant_id=3 first, then 1.
4. Timeout: tx_busy held 0, TIMEOUT=15 -> timeout_err pulses once, 15 cycles after tx_start. frame_cnt unchanged; arb_busy returns to 0; the next grant goes to grant_id+1.
5. Reset in WAIT_DONE: rst low mid-frame -> all outputs 0 immediately, without waiting for a clock edge. After release with req_valid=4'b0001, grant_id=0.
6. Counter wrap: preload via 65535 completed frames, then one more -> frame_cnt goes 0xFFFF->0x0000 with no other side effect.
